// File: rtl/change_dispense_controller.sv
// change_dispense_controller: greedy quarter/dime/nickel change payout with per-hopper inventory,
// drop-sensor confirmation and ack timeout fallback to smaller coins.
module change_dispense_controller #(
  parameter int AMT_W       = 8,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 16,
  parameter int Q_INIT      = 20,
  parameter int D_INIT      = 20,
  parameter int N_INIT      = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [AMT_W-1:0] req_amount,
  output logic             req_ready,
  input  logic             refill_valid,
  input  logic [1:0]       refill_sel,
  input  logic [CNT_W-1:0] refill_qty,
  input  logic             coin_ack,
  output logic             eject_q,
  output logic             eject_d,
  output logic             eject_n,
  output logic             done,
  output logic             short,
  output logic [AMT_W-1:0] remaining,
  output logic             fault,
  output logic             busy,
  output logic [CNT_W-1:0] q_cnt,
  output logic [CNT_W-1:0] d_cnt,
  output logic [CNT_W-1:0] n_cnt
);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [AMT_W-1:0] VQ = AMT_W'(25);
  localparam logic [AMT_W-1:0] VD = AMT_W'(10);
  localparam logic [AMT_W-1:0] VN = AMT_W'(5);
  typedef enum logic [2:0] {IDLE, SELECT, EJECT, WAIT_ACK, DONE} state_t;
  state_t state, state_n;
  logic [AMT_W-1:0] rem, val;
  logic [1:0] sel, pick;
  logic [TW-1:0] timer;
  logic [CNT_W-1:0] cnt [3];
  logic [CNT_W-1:0] cnt_n [3];
  logic accept, tmo, q_ok, d_ok, n_ok, any;
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [CNT_W-1:0] b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction
  assign accept = req_valid && state == IDLE;
  assign tmo = timer == TW'(ACK_TIMEOUT - 1);
  assign q_ok = rem >= VQ && cnt[0] != '0;
  assign d_ok = rem >= VD && cnt[1] != '0;
  assign n_ok = rem >= VN && cnt[2] != '0;
  assign any = q_ok || d_ok || n_ok;
  assign pick = q_ok ? 2'd0 : d_ok ? 2'd1 : 2'd2;
  assign val = sel == 2'd0 ? VQ : sel == 2'd1 ? VD : VN;
  assign req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign eject_q = state == EJECT && sel == 2'd0;
  assign eject_d = state == EJECT && sel == 2'd1;
  assign eject_n = state == EJECT && sel == 2'd2;
  assign done = state == DONE;
  assign short = done && rem != '0;
  assign q_cnt = cnt[0];
  assign d_cnt = cnt[1];
  assign n_cnt = cnt[2];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = accept ? SELECT : IDLE;
      SELECT:   state_n = any ? EJECT : DONE;
      EJECT:    state_n = WAIT_ACK;
      WAIT_ACK: state_n = (coin_ack || tmo) ? SELECT : WAIT_ACK;
      DONE:     state_n = IDLE;
      default:  state_n = IDLE;
    endcase
  end
  // Ack decrements after the refill add; a timeout discards old inventory but keeps this cycle's refill.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      logic [CNT_W-1:0] add, sum;
      logic mine;
      add = (refill_valid && refill_sel == 2'(i + 1)) ? refill_qty : '0;
      sum = sat_add(cnt[i], add);
      mine = state == WAIT_ACK && sel == 2'(i);
      cnt_n[i] = (mine && coin_ack) ? sum - 1'b1 : (mine && tmo) ? add : sum;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rem <= '0;
      sel <= '0;
      timer <= '0;
      fault <= 1'b0;
      remaining <= '0;
      cnt[0] <= CNT_W'(Q_INIT);
      cnt[1] <= CNT_W'(D_INIT);
      cnt[2] <= CNT_W'(N_INIT);
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      if (accept) begin
        rem <= req_amount;
        fault <= 1'b0;
        remaining <= '0;
      end
      if (state == SELECT) begin
        sel <= pick;
        if (!any) remaining <= rem;
      end
      if (state == EJECT) timer <= '0;
      if (state == WAIT_ACK) begin
        if (coin_ack) rem <= rem - val;
        else if (tmo) fault <= 1'b1;
        else timer <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_change_dispense_controller.sv
// tb_change_dispense_controller: directed scenarios plus randomized traffic, checked every cycle
// against a payout model built from coin values and hopper counts.
module tb_change_dispense_controller;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, refill_valid = 0, coin_ack = 0;
  logic [7:0] req_amount = 0, refill_qty = 0;
  logic [1:0] refill_sel = 0;
  logic req_ready, eject_q, eject_d, eject_n, done, short, fault, busy;
  logic [7:0] remaining, q_cnt, d_cnt, n_cnt;
  int checks = 0, fails = 0;
  int drop_n = 0;
  bit drop_all = 0, rnd_dly = 0, noise = 0;
  bit got_done, d_short, d_fault;
  int d_rem;
  int m_ph = 0, m_rem = 0, m_cur = 0, m_t = 0, m_remaining = 0;
  bit m_fault = 0;
  int m_cnt [3] = '{20, 20, 20};
  int val [3] = '{25, 10, 5};

  change_dispense_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_amount(req_amount), .req_ready(req_ready),
    .refill_valid(refill_valid), .refill_sel(refill_sel), .refill_qty(refill_qty), .coin_ack(coin_ack),
    .eject_q(eject_q), .eject_d(eject_d), .eject_n(eject_n), .done(done), .short(short),
    .remaining(remaining), .fault(fault), .busy(busy), .q_cnt(q_cnt), .d_cnt(d_cnt), .n_cnt(n_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Model phases: 0 idle, 1 deciding next coin, 2 ejecting m_cur, 3 awaiting its ack, 4 reporting done.
  always @(negedge clk) begin
    if (!rst_n) begin
      m_ph = 0; m_rem = 0; m_t = 0; m_remaining = 0; m_fault = 0;
      m_cnt = '{20, 20, 20};
    end
    chk("req_ready", req_ready, m_ph == 0);
    chk("busy", busy, m_ph != 0);
    chk("eject_q", eject_q, m_ph == 2 && m_cur == 0);
    chk("eject_d", eject_d, m_ph == 2 && m_cur == 1);
    chk("eject_n", eject_n, m_ph == 2 && m_cur == 2);
    chk("done", done, m_ph == 4);
    chk("short", short, m_ph == 4 && m_rem != 0);
    chk("remaining", remaining, m_remaining);
    chk("fault", fault, m_fault);
    chk("q_cnt", q_cnt, m_cnt[0]);
    chk("d_cnt", d_cnt, m_cnt[1]);
    chk("n_cnt", n_cnt, m_cnt[2]);
    if (rst_n) begin
      int add [3];
      int nc [3];
      for (int i = 0; i < 3; i++) begin
        add[i] = (refill_valid && refill_sel == 2'(i + 1)) ? int'(refill_qty) : 0;
        nc[i] = (m_cnt[i] + add[i] > 255) ? 255 : m_cnt[i] + add[i];
      end
      case (m_ph)
        0: if (req_valid) begin m_rem = req_amount; m_fault = 0; m_remaining = 0; m_ph = 1; end
        1: begin
          m_cur = -1;
          for (int i = 0; i < 3; i++) if (m_cur < 0 && val[i] <= m_rem && m_cnt[i] > 0) m_cur = i;
          if (m_cur < 0) begin m_remaining = m_rem; m_ph = 4; end
          else m_ph = 2;
        end
        2: begin m_t = 0; m_ph = 3; end
        3: if (coin_ack) begin m_rem -= val[m_cur]; nc[m_cur]--; m_ph = 1; end
           else if (m_t == 15) begin nc[m_cur] = add[m_cur]; m_fault = 1; m_ph = 1; end
           else m_t++;
        default: m_ph = 0;
      endcase
      m_cnt = nc;
    end
  end

  // Drop sensor: answers each eject after a delay, can drop acks, can inject stray pulses.
  initial begin
    int wt = -1;
    forever begin
      @(posedge clk);
      #1;
      coin_ack = (wt == 0) || (noise && $urandom_range(0, 9) == 0);
      if (wt >= 0) wt--;
      @(negedge clk);
      if (eject_q || eject_d || eject_n) begin
        wt = (drop_all || drop_n > 0) ? -1 : rnd_dly ? int'($urandom_range(0, 18)) : 0;
        if (drop_n > 0) drop_n--;
      end
    end
  end

  task automatic send(input int amt);
    tick;
    for (int i = 0; i < 200 && !req_ready; i++) tick;
    req_valid = 1;
    req_amount = 8'(amt);
    tick;
    req_valid = 0;
  endtask

  task automatic wait_done(input int lim);
    got_done = 0;
    for (int i = 0; i < lim && !got_done; i++) begin
      @(negedge clk);
      if (done) begin got_done = 1; d_short = short; d_rem = remaining; d_fault = fault; end
    end
    chk("done_seen", got_done, 1);
  endtask

  task automatic refill(input int s, input int q);
    refill_valid = 1; refill_sel = 2'(s); refill_qty = 8'(q);
    tick;
    refill_valid = 0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_q", q_cnt, 20);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    tick;
    send(40);
    wait_done(100);
    chk("t1_short", d_short, 0);
    chk("t1_rem", d_rem, 0);
    chk("t1_cnts", {q_cnt, d_cnt, n_cnt}, {8'd19, 8'd19, 8'd19});
    drop_n = 1;
    send(25);
    wait_done(200);
    chk("t3_fault", d_fault, 1);
    chk("t3_short", d_short, 0);
    chk("t3_cnts", {q_cnt, d_cnt, n_cnt}, {8'd0, 8'd17, 8'd18});
    send(50);
    wait_done(200);
    chk("t2_short", d_short, 0);
    chk("t2_fault", d_fault, 0);
    chk("t2_cnts", {q_cnt, d_cnt}, {8'd0, 8'd12});
    refill(1, 1);
    send(25);
    tick;
    tick;
    refill(1, 10);
    wait_done(100);
    chk("t5_q", q_cnt, 10);
    send(7);
    wait_done(100);
    chk("t5_short", d_short, 1);
    chk("t5_rem", d_rem, 2);
    chk("t5_n", n_cnt, 17);
    drop_all = 1;
    send(40);
    wait_done(300);
    drop_all = 0;
    chk("t4a_rem", d_rem, 40);
    chk("t4a_cnts", {q_cnt, d_cnt, n_cnt}, 0);
    send(30);
    @(negedge clk);
    chk("t4_sel_done", done, 0);
    chk("t4_noeject", {eject_q, eject_d, eject_n}, 0);
    @(negedge clk);
    chk("t4_done", done, 1);
    chk("t4_short", short, 1);
    chk("t4_rem", remaining, 30);
    tick;
    refill(3, 250);
    refill(3, 250);
    chk("sat_n", n_cnt, 255);
    refill(0, 9);
    chk("sel0_q", q_cnt, 0);
    refill(1, 5);
    drop_n = 1;
    send(25);
    tick;
    tick;
    rst_n = 0;
    #1;
    chk("t6_eject", {eject_q, eject_d, eject_n}, 0);
    chk("t6_done", done, 0);
    chk("t6_q", q_cnt, 20);
    tick;
    rst_n = 1;
    tick;
    chk("t6_ready", req_ready, 1);
    chk("t6_busy", busy, 0);
    noise = 1;
    rnd_dly = 1;
    repeat (3000) begin
      tick;
      req_valid = $urandom_range(0, 3) == 0;
      req_amount = $urandom_range(0, 1) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
      refill_valid = $urandom_range(0, 11) == 0;
      refill_sel = 2'($urandom_range(0, 3));
      refill_qty = $urandom_range(0, 7) == 0 ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 6));
    end
    tick;
    req_valid = 0;
    refill_valid = 0;
    noise = 0;
    repeat (5) tick;
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
